// File: rtl/bk_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung prefix network.
// pg_t carries one (generate, propagate) pair; pg_dot is the prefix operator.
package bk_pkg;

  localparam int BK_WIDTH  = 32;
  localparam int BK_LEVELS = $clog2(BK_WIDTH + 1);

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // (g,p) o (g',p') = (g | p&g', p&p'); hi is the more significant group.
  function automatic pg_t pg_dot(pg_t hi, pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_pg_cell.sv
// One Brent-Kung dot-operator node: merges a high group with the adjacent
// lower group into a single (g,p) pair.
module bk_pg_cell
  import bk_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  pg_t res;

  assign res = pg_dot(pg_t'{g: g_hi, p: p_hi}, pg_t'{g: g_lo, p: p_lo});
  assign g   = res.g;
  assign p   = res.p;

endmodule

// File: rtl/bk_prefix_pipe.sv
// Three-stage Brent-Kung generate/propagate prefix network with a stallable
// valid/ready pipeline: PG registers, up-sweep registers, down-sweep registers.
module bk_prefix_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic           cin_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] p_o,
  output logic [WIDTH:0] g_o
);

  // Position 0 carries cin; positions beyond N-1 act as (0,0) padding and
  // are simply never instanced, so they cannot disturb the real positions.
  localparam int N = WIDTH + 1;
  localparam int L = $clog2(N);

  // Handshake: a beat moves on a clock edge when valid & ready are both high.
  // A stage loads when it is empty or the stage after it is loading, so the
  // ready chain runs combinationally from out_ready back to in_ready.
  logic en0, en1, en2;
  logic v0, v1, v2;

  assign en2      = ~v2 | out_ready;
  assign en1      = ~v1 | en2;
  assign en0      = ~v0 | en1;
  assign in_ready = en0;

  logic [N-1:0] s0_g, s0_p;
  logic [N-1:0] s1_g, s1_gp, s1_p;
  logic [N-1:0] s2_g, s2_p;

  // Up-sweep: level k merges node j with node j-2^(k-1) where (j+1) mod 2^k == 0.
  for (genvar k = 0; k <= L; k++) begin : up
    logic [N-1:0] ug, upp;
    if (k == 0) begin : l0
      assign ug  = s0_g;
      assign upp = s0_p;
    end else begin : lk
      for (genvar j = 0; j < N; j++) begin : node
        if (((j + 1) % (1 << k)) == 0) begin : dot
          bk_pg_cell u_cell (
            .g_hi (up[k-1].ug[j]),
            .p_hi (up[k-1].upp[j]),
            .g_lo (up[k-1].ug[j-(1<<(k-1))]),
            .p_lo (up[k-1].upp[j-(1<<(k-1))]),
            .g    (ug[j]),
            .p    (upp[j])
          );
        end else begin : pass
          assign ug[j]  = up[k-1].ug[j];
          assign upp[j] = up[k-1].upp[j];
        end
      end
    end
  end

  // Down-sweep: each remaining position is filled exactly once, so its own
  // group propagate is still the registered up-sweep value.
  for (genvar k = L; k >= 1; k--) begin : dn
    logic [N-1:0] dg;
    if (k == L) begin : top
      assign dg = s1_g;
    end else begin : lk
      for (genvar j = 0; j < N; j++) begin : node
        if ((((j + 1) % (1 << k)) == (1 << (k - 1))) && (j >= (1 << k))) begin : dot
          logic p_unused;
          bk_pg_cell u_cell (
            .g_hi (dn[k+1].dg[j]),
            .p_hi (s1_gp[j]),
            .g_lo (dn[k+1].dg[j-(1<<(k-1))]),
            .p_lo (s1_gp[j-(1<<(k-1))]),
            .g    (dg[j]),
            .p    (p_unused)
          );
        end else begin : pass
          assign dg[j] = dn[k+1].dg[j];
        end
      end
    end
  end

  logic gp_unused;
  assign gp_unused = ^s1_gp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      s0_g  <= '0;
      s0_p  <= '0;
      s1_g  <= '0;
      s1_gp <= '0;
      s1_p  <= '0;
      s2_g  <= '0;
      s2_p  <= '0;
    end else begin
      if (en0) begin
        v0   <= in_valid;
        s0_g <= {a_i & b_i, cin_i};
        s0_p <= {a_i ^ b_i, 1'b0};
      end
      if (en1) begin
        v1    <= v0;
        s1_g  <= up[L].ug;
        s1_gp <= up[L].upp;
        s1_p  <= s0_p;
      end
      if (en2) begin
        v2   <= v1;
        s2_g <= dn[1].dg;
        s2_p <= s1_p;
      end
    end
  end

  assign out_valid = v2;
  assign p_o       = s2_p;
  assign g_o       = s2_g;

endmodule
